// File: rtl/asic_seq_multiplier.sv
// Sequential shift-add WIDTH x WIDTH unsigned multiplier with a start/busy/done
// handshake, plus a multiplexed hex 7-segment scan of the last product.
module asic_seq_multiplier #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MAX_COUNT  = 1250,
  localparam int unsigned NUM_DIGITS = (2 * WIDTH + 3) / 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        i_factor_a,
  input  logic [WIDTH-1:0]        i_factor_b,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [2*WIDTH-1:0]      o_product,
  output logic [6:0]              o_segments,
  output logic [NUM_DIGITS-1:0]   o_digit_sel
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned STEP_W = $clog2(WIDTH + 1);
  localparam int unsigned PRE_W  = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PAD_W  = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [PW-1:0]        product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [PRE_W-1:0]       pre_q, pre_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DIGITS-1:0]  sel_q, sel_d;
  logic [PW-1:0]          snap_q, snap_d;
  logic [3:0]             digit_q, digit_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      step_q    <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Control and shift-add datapath: one multiplier bit consumed per RUN cycle.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    step_d    = step_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          mcand_d  = PW'(i_factor_a);
          mplier_d = i_factor_b;
          acc_d    = '0;
          step_d   = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + STEP_W'(1);
        if (step_q == STEP_W'(WIDTH - 1)) begin
          product_d = acc_d;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q   <= '0;
      idx_q   <= '0;
      sel_q   <= NUM_DIGITS'(1);
      snap_q  <= '0;
      digit_q <= '0;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      snap_q  <= snap_d;
      digit_q <= digit_d;
    end
  end

  // Digit scan; a frame always starts from a fresh snapshot so nibbles never mix.
  always_comb begin
    pre_d   = pre_q + PRE_W'(1);
    idx_d   = idx_q;
    sel_d   = sel_q;
    snap_d  = snap_q;
    digit_d = digit_q;
    if (pre_q == PRE_W'(MAX_COUNT)) begin
      pre_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d   = '0;
        snap_d  = product_q;
        digit_d = 4'(PAD_W'(product_q));
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        digit_d = 4'(PAD_W'(snap_q) >> {idx_d, 2'b00});
      end
      sel_d = NUM_DIGITS'(1) << idx_d;
    end
  end

  always_comb begin
    o_segments = 7'h00;
    case (digit_q)
      4'h0: o_segments = 7'h3F;
      4'h1: o_segments = 7'h06;
      4'h2: o_segments = 7'h5B;
      4'h3: o_segments = 7'h4F;
      4'h4: o_segments = 7'h66;
      4'h5: o_segments = 7'h6D;
      4'h6: o_segments = 7'h7D;
      4'h7: o_segments = 7'h07;
      4'h8: o_segments = 7'h7F;
      4'h9: o_segments = 7'h6F;
      4'hA: o_segments = 7'h77;
      4'hB: o_segments = 7'h7C;
      4'hC: o_segments = 7'h39;
      4'hD: o_segments = 7'h5E;
      4'hE: o_segments = 7'h79;
      4'hF: o_segments = 7'h71;
      default: o_segments = 7'h00;
    endcase
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_product   = product_q;
  assign o_digit_sel = sel_q;

endmodule

// File: tb/tb_asic_seq_multiplier.sv
// Scoreboard bench: stimulus pushes expected products, per-DUT monitors pop on o_done.
module tb_asic_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  a4 = '0, b4 = '0;
  logic        st4 = 1'b0;
  logic        busy4, done4;
  logic [7:0]  prod4;
  logic [6:0]  seg4;
  logic [1:0]  sel4;

  logic [5:0]  a6 = '0, b6 = '0;
  logic        st6 = 1'b0;
  logic        busy6, done6;
  logic [11:0] prod6;
  logic [6:0]  seg6;
  logic [2:0]  sel6;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] prod;
    int          start;
  } exp_t;

  exp_t q4[$];
  exp_t q6[$];

  asic_seq_multiplier #(.WIDTH(4), .MAX_COUNT(3)) dut4 (
    .clk(clk), .reset(rst_n), .i_factor_a(a4), .i_factor_b(b4), .i_start(st4),
    .o_busy(busy4), .o_done(done4), .o_product(prod4), .o_segments(seg4), .o_digit_sel(sel4)
  );

  asic_seq_multiplier #(.WIDTH(6), .MAX_COUNT(3)) dut6 (
    .clk(clk), .reset(rst_n), .i_factor_a(a6), .i_factor_b(b6), .i_start(st6),
    .o_busy(busy6), .o_done(done6), .o_product(prod6), .o_segments(seg6), .o_digit_sel(sel6)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && done4) begin
      if (q4.size() == 0) check("done4_unexpected", 32'(done4), 32'd0);
      else begin
        e = q4.pop_front();
        check("prod4", 32'(prod4), 32'(e.prod));
        check("lat4", 32'(cyc - e.start), 32'd4);
      end
    end
  end

  always @(negedge clk) begin : mon6
    exp_t e;
    if (rst_n && done6) begin
      if (q6.size() == 0) check("done6_unexpected", 32'(done6), 32'd0);
      else begin
        e = q6.pop_front();
        check("prod6", 32'(prod6), 32'(e.prod));
        check("lat6", 32'(cyc - e.start), 32'd6);
      end
    end
  end

  // Called at a negedge; the start is sampled on the following posedge.
  task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p);
    a4 = a; b4 = b; st4 = 1'b1;
    q4.push_back('{prod: 16'(p), start: cyc + 1});
    @(negedge clk);
    st4 = 1'b0;
    check("busy4_after_start", 32'(busy4), 32'd1);
  endtask

  task automatic start6(input logic [5:0] a, input logic [5:0] b, input logic [11:0] p);
    a6 = a; b6 = b; st6 = 1'b1;
    q6.push_back('{prod: 16'(p), start: cyc + 1});
    @(negedge clk);
    st6 = 1'b0;
    check("busy6_after_start", 32'(busy6), 32'd1);
  endtask

  task automatic wait_idle(input bit big, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (((big ? busy6 : busy4) || (big ? q6.size() : q4.size()) != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, 32'(big ? busy6 : busy4), 32'd0);
    check({name, "_pending"}, 32'(big ? q6.size() : q4.size()), 32'd0);
  endtask

  // Wait for o_digit_sel to switch to target, then check the shown glyph.
  task automatic wait_sel(input bit big, input logic [2:0] target, input logic [3:0] nib,
                          input string name, output int n);
    logic [2:0] prev, cur;
    prev = big ? sel6 : 3'(sel4);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      cur = big ? sel6 : 3'(sel4);
      if (cur == target && prev != target) break;
      prev = cur;
      if (n >= 40) break;
    end
    check({name, "_sel"}, 32'(cur), 32'(target));
    check({name, "_seg"}, 32'(big ? seg6 : seg4), 32'(seg7(nib)));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_prod", 32'(prod4), 32'd0);
    check("rst_sel4", 32'(sel4), 32'd1);
    check("rst_seg4", 32'(seg4), 32'(seg7(4'h0)));
    check("rst_sel6", 32'(sel6), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 15 x 15: busy from E, done only after E+4, idle after E+5
    start4(4'd15, 4'd15, 8'hE1);
    repeat (3) begin
      @(negedge clk);
      check("t2_done_early", 32'(done4), 32'd0);
      check("t2_busy", 32'(busy4), 32'd1);
    end
    @(negedge clk);
    check("t2_done", 32'(done4), 32'd1);
    check("t2_prod", 32'(prod4), 32'hE1);
    @(negedge clk);
    check("t2_done_clr", 32'(done4), 32'd0);
    check("t2_busy_clr", 32'(busy4), 32'd0);

    // Display scan of 0xE1, then 0x23 completing while digit 0 is shown
    wait_sel(1'b0, 3'b001, 4'h1, "t4_d0", n);
    wait_sel(1'b0, 3'b010, 4'hE, "t4_d1", n);
    check("t4_dwell", 32'(n), 32'd4);
    start4(4'd5, 4'd7, 8'h23);
    wait_sel(1'b0, 3'b001, 4'h1, "t4_old0", n);
    wait_sel(1'b0, 3'b010, 4'hE, "t4_snap1", n);
    wait_sel(1'b0, 3'b001, 4'h3, "t4_new0", n);
    wait_sel(1'b0, 3'b010, 4'h2, "t4_new1", n);
    check("t4_dwell2", 32'(n), 32'd4);

    // Start during RUN is ignored, operand change has no effect
    wait_idle(1'b0, "t3a");
    start4(4'd3, 4'd5, 8'd15);
    a4 = 4'd7; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    wait_idle(1'b0, "t3b");
    check("t3_prod15", 32'(prod4), 32'd15);
    start4(4'd7, 4'd5, 8'd35);
    wait_idle(1'b0, "t3c");

    // WIDTH=6 product and three-digit scan, then zero operand
    start6(6'd63, 6'd63, 12'hF81);
    wait_idle(1'b1, "t5a");
    wait_sel(1'b1, 3'b001, 4'h1, "t5_d0", n);
    wait_sel(1'b1, 3'b010, 4'h8, "t5_d1", n);
    wait_sel(1'b1, 3'b100, 4'hF, "t5_d2", n);
    start6(6'd0, 6'd42, 12'd0);
    wait_idle(1'b1, "t5b");

    // Reset pulse mid-RUN aborts the operation
    a4 = 4'd3; b4 = 4'd5; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy4), 32'd0);
    check("t6_prod", 32'(prod4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_prod_after", 32'(prod4), 32'd0);
    start4(4'd15, 4'd15, 8'hE1);
    wait_idle(1'b0, "t6");

    // Asynchronous reset in mid-scan while digit 1 shows E
    wait_sel(1'b0, 3'b001, 4'h1, "t1_pre0", n);
    wait_sel(1'b0, 3'b010, 4'hE, "t1_pre1", n);
    #2 rst_n = 1'b0;
    #1;
    check("t1_busy", 32'(busy4), 32'd0);
    check("t1_done", 32'(done4), 32'd0);
    check("t1_prod", 32'(prod4), 32'd0);
    check("t1_sel", 32'(sel4), 32'd1);
    check("t1_seg", 32'(seg4), 32'(seg7(4'h0)));
    repeat (3) @(posedge clk);
    #1;
    check("t1_hold_sel", 32'(sel4), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_rel_sel", 32'(sel4), 32'd1);
    check("t1_rel_prod", 32'(prod4), 32'd0);
    wait_sel(1'b0, 3'b010, 4'h0, "t1_resume", n);
    check("t1_dwell", 32'(n), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asic_seq_multiplier.md
Name: asic_seq_multiplier

Overview:
Parametrised next-generation multiplier/display block. A start/busy/done handshake launches a WIDTH x WIDTH unsigned multiply on a sequential shift-add datapath. The 2*WIDTH-bit product is scanned as hex digits onto one shared 7-segment output with one-hot digit enables. The block sits between the Tiny Tapeout IO pins (switches in, segments/digit enables out) and replaces the fixed 3-bit/2-digit multiplier display.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..8.
MAX_COUNT, 1250, digit dwell; each digit is shown for MAX_COUNT+1 clk cycles.
NUM_DIGITS (localparam), (2*WIDTH+3)/4, number of hex digits scanned; not overridable.

Ports:
clk  input  1  system clock (2500 Hz nominal on board).
reset  input  1  asynchronous, active-low reset.
i_factor_a  input  WIDTH  operand A, unsigned.
i_factor_b  input  WIDTH  operand B, unsigned.
i_start  input  1  start request; sampled only in IDLE.
o_busy  output  1  high in RUN and DONE states.
o_done  output  1  one-cycle pulse when the product is written.
o_product  output  2*WIDTH  last completed product; held until the next completion.
o_segments  output  7  seg7 encoding of the currently selected nibble (existing seg7 decoder).
o_digit_sel  output  NUM_DIGITS  one-hot digit enable; bit 0 is the least significant nibble.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - o_busy=0, o_done=0, o_product=0.
  - Snapshot=0, prescaler=0, digit index=0.
  - o_digit_sel=1 (digit 0), o_segments=seg7(0).
  - Deassertion is synchronous to clk through the normal flop path; no extra synchroniser is inside the block.
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge E with i_start=1:
  - latch the operands: mcand={WIDTH'b0,A}, mplier=B;
  - clear the 2*WIDTH-bit accumulator and step counter;
  - go to RUN.
- RUN: one step per edge, E+1..E+WIDTH.
  - If mplier[0]=1, acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, step++.
  - On the edge where step reaches WIDTH, write the final acc to o_product and go to DONE.
- DONE: o_done=1 for exactly one cycle (after edge E+WIDTH), then go to IDLE at E+WIDTH+1.
- Latency: product is valid and o_done is high WIDTH cycles after the start edge. A new start is accepted from E+WIDTH+1.
- Arithmetic: unsigned with no overflow (2*WIDTH-bit result). Fixed latency; there is no early termination on zero operands.
- i_start while o_busy=1 is ignored (not queued). Operand changes during RUN have no effect.
- Prescaler: counts 0..MAX_COUNT. At terminal count it wraps to 0 and the digit index advances; index NUM_DIGITS-1 wraps to 0.
- Frame snapshot: on the edge where the digit index wraps to 0, the snapshot register loads o_product. If o_done fires on the same edge, the snapshot takes the pre-update o_product value. The display never mixes nibbles of two products within a frame.
- Digit register: on every prescaler wrap, load the snapshot nibble for the new index (zero-padded above bit 2*WIDTH-1). o_digit_sel updates on the same edge. o_segments=seg7(digit register), combinational.
- Reset mid-RUN aborts the operation: no o_done, o_product=0.

Test Plan:
1. reset=0 held for 3 cycles in mid-scan, then released -> o_busy=0, o_done=0, o_product=0, o_digit_sel=1, o_segments=seg7(0); all outputs go to reset values asynchronously, before the next clk edge.
2. WIDTH=4, A=15, B=15, i_start for 1 cycle at edge E -> o_busy=1 from E; o_done=1 only in the cycle after E+4; o_product=0xE1 (225); o_busy=0 after E+5.
3. WIDTH=4, A=3, B=5 started at E; at E+2 assert i_start with A=7 -> single o_done; o_product=15; a start at E+5 with A=7 -> o_product=35.
4. WIDTH=4, MAX_COUNT=3, o_product=0xE1 -> o_digit_sel alternates 01/10 every 4 cycles with nibbles 1/E. Completing 0x23 mid-frame while digit 0 is shown -> digit 1 still shows E; the next frame shows 3 then 2.
5. WIDTH=6, A=63, B=63 -> o_done 6 cycles after start; o_product=0xF81; NUM_DIGITS=3 scan shows 1,8,F. A=0, B=42 -> o_product=0, latency still 6.
6. Pulse reset at E+2 of a WIDTH=4 run -> no o_done; o_product=0; a new start after release completes normally.
